// File: rtl/hs_axi2apb_bridge.sv
// ============================================================================
// Module   : hs_axi2apb_bridge
// Purpose  : Single-outstanding AXI4 slave to APB4 master bridge. Each 64-bit
//            AXI beat becomes one or two 32-bit APB transfers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_axi2apb_bridge #(
    parameter int APB_ADDR_W = 32
) (
    input  logic                  acr_clk,
    input  logic                  acr_rst,
    input  logic [31:0]           axi_awaddr,
    input  logic [3:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awlock,
    input  logic [3:0]            axi_awcache,
    input  logic [2:0]            axi_awprot,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [63:0]           axi_wdata,
    input  logic [7:0]            axi_wstrb,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [7:0]            axi_bid,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic [7:0]            axi_arid,
    input  logic [31:0]           axi_araddr,
    input  logic [3:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic                  axi_arlock,
    input  logic [3:0]            axi_arcache,
    input  logic [2:0]            axi_arprot,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [7:0]            axi_rid,
    output logic [63:0]           axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [APB_ADDR_W-1:0] apb_paddr,
    output logic                  apb_psel,
    output logic                  apb_penable,
    output logic                  apb_pwrite,
    output logic [31:0]           apb_pwdata,
    output logic [3:0]            apb_pstrb,
    output logic [2:0]            apb_pprot,
    input  logic [31:0]           apb_prdata,
    input  logic                  apb_pready,
    input  logic                  apb_pslverr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_BRESP  = 3'd4,
        S_RDATA  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_wr;
    logic        r_ptr_wr;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [1:0]  r_size;
    logic [1:0]  r_burst;
    logic [2:0]  r_prot;
    logic [7:0]  r_id;
    logic [3:0]  r_beat;
    logic        r_half;
    logic        r_err;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic [63:0] r_rdata;

    logic        w_grant_wr;
    logic        w_grant_rd;
    logic        w_aw_hs;
    logic        w_ar_hs;
    logic        w_sel;
    logic        w_lane;
    logic        w_last_sub;
    logic        w_last_beat;
    logic [31:0] w_incr;
    logic [31:0] w_wmask;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_paddr;
    logic        w_unused;

    // Round-robin only matters when both channels request in the same cycle.
    assign w_grant_wr  = axi_awvalid & (~axi_arvalid | r_ptr_wr);
    assign w_grant_rd  = axi_arvalid & (~axi_awvalid | ~r_ptr_wr);
    assign w_aw_hs     = (r_state == S_IDLE) & w_grant_wr;
    assign w_ar_hs     = (r_state == S_IDLE) & w_grant_rd;

    // A 64-bit beat walks both lanes; narrower beats use the lane of addr[2].
    assign w_lane      = (r_size == 2'd3) ? r_half : r_addr[2];
    assign w_last_sub  = (r_size != 2'd3) | r_half;
    assign w_last_beat = (r_beat == r_len);

    assign w_incr  = 32'd1 << r_size;
    assign w_wmask = (({28'd0, r_len} + 32'd1) << r_size) - 32'd1;

    always_comb begin
        w_addr_nxt = r_addr + w_incr;
        case (r_burst)
            2'b00:   w_addr_nxt = r_addr;
            2'b10:   w_addr_nxt = (r_addr & ~w_wmask) | ((r_addr + w_incr) & w_wmask);
            default: w_addr_nxt = r_addr + w_incr;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_aw_hs)      w_state_nxt = S_WDATA;
                else if (w_ar_hs) w_state_nxt = S_SETUP;
            end
            S_WDATA:  if (axi_wvalid) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (apb_pready) begin
                    if (!w_last_sub) w_state_nxt = S_SETUP;
                    else if (r_wr)   w_state_nxt = w_last_beat ? S_BRESP : S_WDATA;
                    else             w_state_nxt = S_RDATA;
                end
            end
            S_BRESP:  if (axi_bready) w_state_nxt = S_IDLE;
            S_RDATA:  if (axi_rready) w_state_nxt = w_last_beat ? S_IDLE : S_SETUP;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge acr_clk or posedge acr_rst) begin
        if (acr_rst) begin
            r_state  <= S_IDLE;
            r_wr     <= 1'b0;
            r_ptr_wr <= 1'b1;
            r_addr   <= 32'd0;
            r_len    <= 4'd0;
            r_size   <= 2'd0;
            r_burst  <= 2'd0;
            r_prot   <= 3'd0;
            r_id     <= 8'd0;
            r_beat   <= 4'd0;
            r_half   <= 1'b0;
            r_err    <= 1'b0;
            r_wdata  <= 64'd0;
            r_wstrb  <= 8'd0;
            r_rdata  <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_wr     <= 1'b1;
                        r_ptr_wr <= 1'b0;
                        r_addr   <= axi_awaddr;
                        r_len    <= axi_awlen;
                        r_size   <= axi_awsize[2] ? 2'd3 : axi_awsize[1:0];
                        r_burst  <= axi_awburst;
                        r_prot   <= axi_awprot;
                        r_id     <= 8'd0;
                        r_beat   <= 4'd0;
                        r_half   <= 1'b0;
                        r_err    <= 1'b0;
                    end else if (w_ar_hs) begin
                        r_wr     <= 1'b0;
                        r_ptr_wr <= 1'b1;
                        r_addr   <= axi_araddr;
                        r_len    <= axi_arlen;
                        r_size   <= axi_arsize[2] ? 2'd3 : axi_arsize[1:0];
                        r_burst  <= axi_arburst;
                        r_prot   <= axi_arprot;
                        r_id     <= axi_arid;
                        r_beat   <= 4'd0;
                        r_half   <= 1'b0;
                        r_err    <= 1'b0;
                        r_rdata  <= 64'd0;
                    end
                end
                S_WDATA: begin
                    if (axi_wvalid) begin
                        r_wdata <= axi_wdata;
                        r_wstrb <= axi_wstrb;
                    end
                end
                S_ACCESS: begin
                    if (apb_pready) begin
                        if (apb_pslverr) r_err <= 1'b1;
                        if (!r_wr) begin
                            if (w_lane) r_rdata[63:32] <= apb_prdata;
                            else        r_rdata[31:0]  <= apb_prdata;
                        end
                        if (!w_last_sub) begin
                            r_half <= 1'b1;
                        end else begin
                            r_half <= 1'b0;
                            if (r_wr && !w_last_beat) begin
                                r_addr <= w_addr_nxt;
                                r_beat <= r_beat + 4'd1;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    // Read error status is per beat, so it restarts with each beat.
                    if (axi_rready && !w_last_beat) begin
                        r_addr  <= w_addr_nxt;
                        r_beat  <= r_beat + 4'd1;
                        r_err   <= 1'b0;
                        r_rdata <= 64'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign axi_awready = w_aw_hs;
    assign axi_arready = w_ar_hs;
    assign axi_wready  = (r_state == S_WDATA);
    assign axi_bvalid  = (r_state == S_BRESP);
    assign axi_bresp   = {axi_bvalid & r_err, 1'b0};
    assign axi_bid     = 8'd0;
    assign axi_rvalid  = (r_state == S_RDATA);
    assign axi_rid     = r_id;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = {axi_rvalid & r_err, 1'b0};
    assign axi_rlast   = axi_rvalid & w_last_beat;

    assign w_sel       = (r_state == S_SETUP) | (r_state == S_ACCESS);
    assign w_paddr     = {r_addr[31:3], w_lane, 2'b00};
    assign apb_paddr   = w_paddr[APB_ADDR_W-1:0];
    assign apb_psel    = w_sel;
    assign apb_penable = (r_state == S_ACCESS);
    assign apb_pwrite  = w_sel & r_wr;
    assign apb_pwdata  = w_lane ? r_wdata[63:32] : r_wdata[31:0];
    assign apb_pstrb   = r_wr ? (w_lane ? r_wstrb[7:4] : r_wstrb[3:0]) : 4'h0;
    assign apb_pprot   = r_prot;

    assign w_unused = ^{axi_awlock, axi_awcache, axi_wlast, axi_arlock, axi_arcache, w_paddr};

endmodule

`default_nettype wire

// File: tb/tb_hs_axi2apb_bridge.sv
// ============================================================================
// Module   : tb_hs_axi2apb_bridge
// Purpose  : Scoreboard bench for hs_axi2apb_bridge with a simple APB slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs_axi2apb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] axi_awaddr;  logic [3:0] axi_awlen;  logic [2:0] axi_awsize;
    logic [1:0]  axi_awburst; logic axi_awlock; logic [3:0] axi_awcache;
    logic [2:0]  axi_awprot;  logic axi_awvalid, axi_awready;
    logic [63:0] axi_wdata;   logic [7:0] axi_wstrb; logic axi_wlast, axi_wvalid, axi_wready;
    logic [7:0]  axi_bid;     logic [1:0] axi_bresp; logic axi_bvalid, axi_bready;
    logic [7:0]  axi_arid;    logic [31:0] axi_araddr; logic [3:0] axi_arlen;
    logic [2:0]  axi_arsize;  logic [1:0] axi_arburst; logic axi_arlock;
    logic [3:0]  axi_arcache; logic [2:0] axi_arprot; logic axi_arvalid, axi_arready;
    logic [7:0]  axi_rid;     logic [63:0] axi_rdata; logic [1:0] axi_rresp;
    logic        axi_rlast, axi_rvalid, axi_rready;
    logic [31:0] apb_paddr;   logic apb_psel, apb_penable, apb_pwrite;
    logic [31:0] apb_pwdata;  logic [3:0] apb_pstrb; logic [2:0] apb_pprot;
    logic [31:0] apb_prdata;  logic apb_pready, apb_pslverr;

    hs_axi2apb_bridge #(.APB_ADDR_W(32)) dut (
        .acr_clk(clk), .acr_rst(rst),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
        .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
        .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
        .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_pprot(apb_pprot), .apb_prdata(apb_prdata), .apb_pready(apb_pready),
        .apb_pslverr(apb_pslverr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; logic [3:0] strb; } apb_t;
    typedef struct { logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;

    apb_t        exp_apb[$];
    rbeat_t      exp_r[$];
    logic [1:0]  exp_b[$];
    bit          grants[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          aw_cyc, ar_cyc, w_cyc, t_setup, t_b, t_r;
    bit          stall = 1'b0;
    bit          err_en = 1'b0;
    bit          rand_rdy = 1'b0;
    int          wait_n = 0;
    int          acc_cnt = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    localparam logic [63:0] c_step = 64'h0101_0101_0101_0101;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] prd(input logic [31:0] a);
        return {16'hC0DE ^ a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] nb, wb, lo, n;
        nb = (size > 3'd3) ? 32'd8 : (32'd1 << size);
        n  = a + nb;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            wb = ({28'd0, len} + 32'd1) * nb;
            lo = (a / wb) * wb;
            if (n >= lo + wb) n = lo;
        end
        return n;
    endfunction

    function automatic logic hit(input logic [31:0] a);
        return err_en && (a == err_addr);
    endfunction

    function automatic void push_apb(input bit wr, input logic [31:0] a, input logic [2:0] size,
                                     input logic [63:0] d, input logic [7:0] s, inout logic err);
        apb_t        t;
        logic [31:0] base;
        t.wr = wr;
        if (size >= 3'd3) begin
            base = a & ~32'h7;
            t.addr = base;        t.data = d[31:0];  t.strb = s[3:0]; exp_apb.push_back(t);
            t.addr = base | 32'h4; t.data = d[63:32]; t.strb = s[7:4]; exp_apb.push_back(t);
            err = err | hit(base) | hit(base | 32'h4);
        end else begin
            base = a & ~32'h3;
            t.addr = base;
            t.data = a[2] ? d[63:32] : d[31:0];
            t.strb = a[2] ? s[7:4] : s[3:0];
            exp_apb.push_back(t);
            err = err | hit(base);
        end
    endfunction

    function automatic logic [63:0] rexp(input logic [31:0] a, input logic [2:0] size);
        logic [31:0] base;
        if (size >= 3'd3) begin
            base = a & ~32'h7;
            return {prd(base | 32'h4), prd(base)};
        end
        base = a & ~32'h3;
        return a[2] ? {prd(base), 32'h0} : {32'h0, prd(base)};
    endfunction

    // APB slave: optional wait states, programmable error address, stall for abort test.
    always_comb begin
        apb_pready  = apb_psel && apb_penable && !stall && (acc_cnt >= wait_n);
        apb_prdata  = prd(apb_paddr);
        apb_pslverr = apb_pready && err_en && (apb_paddr == err_addr);
    end
    always @(posedge clk) acc_cnt <= (apb_psel && apb_penable && !apb_pready) ? acc_cnt + 1 : 0;

    always @(posedge clk) begin
        #1;
        axi_rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    apb_t        m_a;
    rbeat_t      m_r;
    logic [1:0]  m_b;
    logic [36:0] snap_ctl;
    logic [31:0] snap_wd;
    bit          r_hold = 1'b0;
    logic [10:0] r_prev_ctl;
    logic [63:0] r_prev_data;

    always @(negedge clk) begin
        if (apb_psel && !apb_penable) begin
            snap_ctl = {apb_pwrite, apb_pstrb, apb_paddr};
            snap_wd  = apb_pwdata;
            if (t_setup < 0) t_setup = cyc;
        end
        if (apb_psel && apb_penable) begin
            check("apb_stable_ctl", {apb_pwrite, apb_pstrb, apb_paddr}, snap_ctl);
            check("apb_stable_wd", apb_pwdata, snap_wd);
        end
        if (apb_psel && apb_penable && apb_pready) begin
            if (exp_apb.size() == 0) check("apb_unexpected", 1, 0);
            else begin
                m_a = exp_apb.pop_front();
                check("apb_addr", apb_paddr, m_a.addr);
                check("apb_write", apb_pwrite, m_a.wr);
                if (m_a.wr) begin
                    check("apb_wdata", apb_pwdata, m_a.data);
                    check("apb_strb", apb_pstrb, m_a.strb);
                end
            end
        end
        if (axi_bvalid && t_b < 0) t_b = cyc;
        if (axi_bvalid && axi_bready) begin
            if (exp_b.size() == 0) check("b_unexpected", 1, 0);
            else begin
                m_b = exp_b.pop_front();
                check("bresp", axi_bresp, m_b);
                check("bid", axi_bid, 0);
            end
        end
        if (r_hold) begin
            check("r_stable_ctl", {axi_rvalid, axi_rlast, axi_rresp, axi_rid}, {1'b1, r_prev_ctl});
            check("r_stable_data", axi_rdata, r_prev_data);
        end
        r_hold = axi_rvalid && !axi_rready;
        r_prev_ctl  = {axi_rlast, axi_rresp, axi_rid};
        r_prev_data = axi_rdata;
        if (axi_rvalid && t_r < 0) t_r = cyc;
        if (axi_rvalid && axi_rready) begin
            if (exp_r.size() == 0) check("r_unexpected", 1, 0);
            else begin
                m_r = exp_r.pop_front();
                check("rid", axi_rid, m_r.id);
                check("rdata", axi_rdata, m_r.data);
                check("rresp", axi_rresp, m_r.resp);
                check("rlast", axi_rlast, m_r.last);
            end
        end
    end

    task automatic axi_wr(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [63:0] seed, input logic [7:0] strb);
        int          beat = 0;
        int          g = 0;
        bit          aw_done = 1'b0;
        bit          whs;
        logic [31:0] a;
        logic        err;
        @(posedge clk); #1;
        axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
        axi_awprot = 3'd2; axi_awvalid = 1'b1;
        axi_wdata = seed; axi_wstrb = strb; axi_wlast = (len == 4'd0); axi_wvalid = 1'b1;
        while ((axi_awvalid || axi_wvalid) && g < 300) begin
            @(negedge clk);
            if (axi_awvalid && axi_awready) begin
                aw_done = 1'b1; aw_cyc = cyc; grants.push_back(1'b1);
                a = addr; err = 1'b0;
                for (int k = 0; k <= int'(len); k++) begin
                    push_apb(1'b1, a, size, seed + 64'(k) * c_step, strb, err);
                    a = next_addr(a, len, size, burst);
                end
                exp_b.push_back(err ? 2'b10 : 2'b00);
            end
            whs = axi_wvalid && axi_wready;
            if (whs && w_cyc < 0) w_cyc = cyc;
            @(posedge clk); #1;
            if (aw_done) axi_awvalid = 1'b0;
            if (whs) begin
                beat++;
                axi_wdata = seed + 64'(beat) * c_step;
                axi_wlast = (beat == int'(len));
                if (beat > int'(len)) axi_wvalid = 1'b0;
            end
            g++;
        end
        if (g >= 300) begin
            check("wr_timeout", 1, 0);
            axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        end
    endtask

    task automatic axi_rd(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int          g = 0;
        bit          hs = 1'b0;
        logic [31:0] a;
        logic        err;
        rbeat_t      rb;
        @(posedge clk); #1;
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = size;
        axi_arburst = burst; axi_arprot = 3'd1; axi_arvalid = 1'b1;
        while (axi_arvalid && g < 300) begin
            @(negedge clk);
            if (axi_arready) begin
                hs = 1'b1; ar_cyc = cyc; grants.push_back(1'b0);
                a = addr;
                for (int k = 0; k <= int'(len); k++) begin
                    err = 1'b0;
                    push_apb(1'b0, a, size, 64'd0, 8'd0, err);
                    rb.id = id; rb.data = rexp(a, size);
                    rb.resp = err ? 2'b10 : 2'b00; rb.last = (k == int'(len));
                    exp_r.push_back(rb);
                    a = next_addr(a, len, size, burst);
                end
            end
            @(posedge clk); #1;
            if (hs) axi_arvalid = 1'b0;
            g++;
        end
        if (g >= 300) begin
            check("rd_timeout", 1, 0);
            axi_arvalid = 1'b0;
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_apb.size() != 0 || exp_b.size() != 0 || exp_r.size() != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("drain_timeout", (g >= 3000), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0; axi_awlock = 1'b0;
        axi_awcache = '0; axi_awprot = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b1;
        axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = '0;
        axi_arlock = 1'b0; axi_arcache = '0; axi_arprot = '0; axi_arvalid = 1'b0; axi_rready = 1'b1;
        aw_cyc = 0; ar_cyc = 0; w_cyc = -1; t_setup = -1; t_b = -1; t_r = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast,
                          apb_psel, apb_penable, apb_pwrite}, 0);
        check("rst_payload", {axi_bid, axi_rid, axi_bresp, axi_rresp, apb_pstrb, apb_pprot}, 0);
        check("rst_paddr", apb_paddr, 0);
        check("rst_rdata", axi_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single write: latency and lane selection.
        w_cyc = -1; t_setup = -1; t_b = -1;
        axi_wr(32'h104, 4'd0, 3'd2, 2'b01, 64'hAABBCCDD_11223344, 8'hF0);
        drain();
        check("wr_lat_wready", w_cyc - aw_cyc, 1);
        check("wr_lat_setup", t_setup - aw_cyc, 2);
        check("wr_lat_bvalid", t_b - aw_cyc, 4);

        // Error on the middle beat only.
        err_en = 1'b1; err_addr = 32'h304;
        axi_wr(32'h300, 4'd2, 3'd2, 2'b01, 64'h1111_2222_3333_4444, 8'hFF);
        drain();
        err_en = 1'b0;

        axi_wr(32'h400, 4'd1, 3'd3, 2'b01, 64'hDEAD_BEEF_CAFE_F00D, 8'h3C);
        drain();

        // Single read latency.
        t_setup = -1; t_r = -1;
        axi_rd(8'h01, 32'h10, 4'd0, 3'd2, 2'b01);
        drain();
        check("rd_lat_setup", t_setup - ar_cyc, 1);
        check("rd_lat_rvalid", t_r - ar_cyc, 3);

        rand_rdy = 1'b1;
        axi_rd(8'h5A, 32'h200, 4'd3, 3'd3, 2'b01);
        drain();
        rand_rdy = 1'b0;

        wait_n = 2;
        axi_rd(8'h11, 32'h38, 4'd3, 3'd3, 2'b10);
        drain();
        wait_n = 0;

        axi_rd(8'h22, 32'h1006, 4'd1, 3'd1, 2'b00);
        drain();

        // Both address channels requesting: grants must alternate.
        grants.delete();
        fork
            begin
                axi_wr(32'h600, 4'd0, 3'd2, 2'b01, 64'h0A0B_0C0D_0E0F_1011, 8'h0F);
                axi_wr(32'h608, 4'd1, 3'd2, 2'b01, 64'h5566_7788_99AA_BBCC, 8'hF0);
            end
            axi_rd(8'h77, 32'h700, 4'd1, 3'd2, 2'b01);
        join
        drain();
        check("grant_count", grants.size(), 3);
        if (grants.size() == 3) begin
            check("grant_0_wr", grants[0], 1);
            check("grant_1_rd", grants[1], 0);
            check("grant_2_wr", grants[2], 1);
        end

        // Abort mid-ACCESS with reset.
        stall = 1'b1;
        axi_wr(32'h500, 4'd0, 3'd2, 2'b01, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        for (int g = 0; g < 50 && !(apb_psel && apb_penable); g++) @(negedge clk);
        check("abort_in_access", apb_psel && apb_penable, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_drop", {apb_psel, apb_penable, axi_bvalid, axi_rvalid}, 0);
        exp_apb.delete(); exp_b.delete(); exp_r.delete();
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        axi_rd(8'h33, 32'h80, 4'd0, 3'd2, 2'b01);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
